// File: rtl/tc_bus_arbiter.sv
// Round-robin owner arbiter and receiver for a shared TC_Switch bus segment.
// Grants one driver at a time, forces a dead turnaround cycle between owners and captures bus data.
module tc_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N-1:0]                     req,
   input  logic [W-1:0]                     bus_in,
   output logic [N-1:0]                     en,
   output logic                             busy,
   output logic                             rx_valid,
   output logic [W-1:0]                     rx_data,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] rx_src
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_TURN  = 2'd2;

   logic [1:0]    state_reg;
   logic [SW-1:0] owner_reg;
   logic [SW-1:0] last_reg;
   logic [7:0]    hold_reg;
   logic [7:0]    hold_next;

   logic [SW-1:0] pick;
   logic          pick_valid;
   logic [N-1:0]  pick_onehot;
   int            idx;

   assign hold_next = hold_reg + 8'd1;

   // Search starts just after the previous owner; walking the offsets downward
   // lets the nearest requester overwrite any farther one.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      idx        = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(last_reg) + 1 + k) % N;
         if (req[idx]) begin
            pick       = SW'(idx);
            pick_valid = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_onehot
         assign pick_onehot[gi] = (pick == SW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
         owner_reg <= '0;
         last_reg  <= SW'(N - 1);
         hold_reg  <= '0;
         en        <= '0;
         busy      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
         rx_src    <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (state_reg)
            S_GRANT: begin
               if (req[owner_reg]) begin
                  rx_data  <= bus_in;
                  rx_src   <= owner_reg;
                  rx_valid <= 1'b1;
                  hold_reg <= hold_next;
                  if (hold_next == 8'(MAX_HOLD)) begin
                     en        <= '0;
                     busy      <= 1'b0;
                     last_reg  <= owner_reg;
                     state_reg <= S_TURN;
                  end
               end else begin
                  en        <= '0;
                  busy      <= 1'b0;
                  last_reg  <= owner_reg;
                  state_reg <= S_TURN;
               end
            end
            default: begin
               // IDLE and TURN both arbitrate; TURN has already held en low for one cycle.
               if (pick_valid) begin
                  owner_reg <= pick;
                  en        <= pick_onehot;
                  busy      <= 1'b1;
                  hold_reg  <= '0;
                  state_reg <= S_GRANT;
               end else begin
                  en        <= '0;
                  busy      <= 1'b0;
                  state_reg <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/tc_bus_arbiter.md
# tc_bus_arbiter

Round-robin owner arbiter and receiver for a shared tri-state bus built from TC_Switch drivers. Drives the per-driver enable lines so that at most one TC_Switch owns the bus at any time, inserts a mandatory turnaround cycle between owners, and captures the resolved bus value into a registered receive port tagged with the source index. It sits at the listening end of every multi-driver bus segment.

## Interface
Parameters:
- N, 4, number of drivers/requesters on the bus (2..16)
- W, 8, bus width
- MAX_HOLD, 4, maximum transfers per grant before forced release (1..255)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N  request from driver i; high means driver i has valid data to put on the bus
- bus_in  input  W  resolved shared bus value (outputs of all TC_Switch instances joined)
- en  output  N  one-hot-or-zero enable to TC_Switch i; registered
- busy  output  1  high while in GRANT; registered
- rx_valid  output  1  one-cycle pulse: rx_data/rx_src hold a new captured transfer
- rx_data  output  W  captured bus value
- rx_src  output  clog2(N) (min 1)  index of the driver that produced rx_data

## Operation
- States: IDLE, GRANT, TURN. Internal: owner index, last owner pointer, hold counter (8 bit).
- Reset (async, immediate): state IDLE, en=0, busy=0, rx_valid=0, rx_data=0, rx_src=0, hold=0, last=N-1 (so req[0] wins first).
- Arbitration (in IDLE and TURN): if req nonzero, pick first set bit searching (last+1) mod N upward with wrap; owner<=pick, en<=onehot(pick), busy<=1, hold<=0, state GRANT. If req zero: stay IDLE (from TURN go to IDLE), en=0.
- GRANT, each edge:
  - req[owner]=1: capture rx_data<=bus_in, rx_src<=owner, rx_valid<=1, hold<=hold+1. If hold+1==MAX_HOLD: en<=0, busy<=0, last<=owner, state TURN. Else remain.
  - req[owner]=0: no capture, rx_valid<=0, en<=0, busy<=0, last<=owner, state TURN.
- TURN: en is all-zero for this cycle; arbitration runs at its closing edge (back-to-back grants separated by exactly one dead cycle).
- rx_valid is 0 on every edge not described as a capture; rx_data/rx_src hold their last captured value.
- Requests of non-owners during GRANT are ignored (no preemption). Requests from a driver in the TURN cycle compete normally.
- Invariant: popcount(en) <= 1 at all times; en never changes directly from one nonzero value to another.

## Timing
- Request-to-enable latency: req rising before edge k -> en high from edge k (1 cycle).
- Data capture: bus_in sampled at the edge ending each GRANT cycle with req[owner]=1; rx_valid visible the cycle after that bus cycle.
- Forced release: owner holding req continuously gets exactly MAX_HOLD captures, then 1 TURN cycle, then is re-granted only if no other requester in round-robin order precedes it.
- Single requester continuously requesting: pattern MAX_HOLD GRANT cycles, 1 TURN cycle, repeat.
- Owner drops req mid-grant: that cycle yields no capture; TURN follows.
- Reset mid-GRANT: en and rx_valid drop asynchronously the instant rst rises; no capture completes; first grant after reset goes to lowest-index requester.

## Test plan
- Reset: assert rst mid-GRANT with en=0100 -> en=0000, rx_valid=0, busy=0 immediately; after release req=1111 -> en=0001 first.
- Single driver: req=0010, bus_in=8'hA5 held, MAX_HOLD=4 -> en=0010 for 4 cycles, rx_valid pulses 4 times with rx_data=A5, rx_src=1, then 1 cycle en=0000, then re-grant.
- Round robin: req=1111 continuous -> owners 0,1,2,3,0 each 4 captures, en=0000 one cycle between each, popcount(en)<=1 every cycle.
- Early release: req[2] high 2 cycles then low, bus_in=8'h3C -> exactly 2 captures rx_src=2, TURN, IDLE if no other req.
- Late arrival: req[3] rises while driver 0 owns -> no preemption; driver 3 granted right after driver 0's TURN cycle.
- Wrap: last=3, req=1001 -> driver 0 granted before driver 3.
